// File: rtl/load_register_if.sv
// Bus bundle for load_register: data in, load enable, stored word out.
// load is a plain level enable with no ready path; a word is taken on every rising edge where load is high.
interface load_register_if #(
  parameter int WIDTH = 32
) ();
  logic [WIDTH-1:0] in;
  logic             load;
  logic [WIDTH-1:0] out;

  modport master (
    output in,
    output load,
    input  out
  );

  modport slave (
    input  in,
    input  load,
    output out
  );
endinterface

// File: rtl/load_register.sv
// WIDTH-bit storage register: per-bit hold/load select feeding a rising-edge flop,
// with an asynchronous active-low clear that overrides load.
module load_register #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  load_register_if.slave bus
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;

  // One cell per bit: the mux recirculates q so that load = 0 holds the word.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign d[i] = bus.load ? bus.in[i] : q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

  assign bus.out = q;

endmodule

// File: tb/tb_load_register.sv
// Bench for load_register: directed steps plus random traffic against a word-level model,
// on a 32-bit instance and a 1-bit instance sharing clock and reset.
module tb_load_register;

  logic clk;
  logic rst_n;

  load_register_if #(.WIDTH(32)) bus ();
  load_register_if #(.WIDTH(1))  bus1 ();

  load_register #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  load_register #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the word the register must hold, updated from what was driven at each edge.
  logic [31:0] exp32;
  logic        exp1;
  int n_checks;
  int n_pass;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // Advance one rising edge, apply the load rule to the model, then settle away from the edge.
  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      if (bus.load)  exp32 = bus.in;
      if (bus1.load) exp1  = bus1.in;
    end
    #1;
  endtask

  task automatic check_both(input string tag);
    check({tag, "_w32"}, {32'h0, bus.out}, {32'h0, exp32});
    check({tag, "_w1"},  {63'h0, bus1.out}, {63'h0, exp1});
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    exp32    = '0;
    exp1     = 1'b0;
    rst_n    = 1'b0;
    bus.in   = 32'hFFFF_FFFF;
    bus.load = 1'b1;
    bus1.in  = 1'b1;
    bus1.load = 1'b1;

    // Reset held with load high: output must stay zero through several edges.
    #1;
    check("reset_t0", {32'h0, bus.out}, 64'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_hold", {32'h0, bus.out}, 64'h0);
      check("reset_hold_w1", {63'h0, bus1.out}, 64'h0);
    end

    // Release between edges with load low: still zero after the next edge.
    @(negedge clk);
    bus.load  = 1'b0;
    bus1.load = 1'b0;
    rst_n     = 1'b1;
    step();
    check("release_no_load", {32'h0, bus.out}, 64'h0);

    // Basic load of zero.
    bus.in   = 32'h0;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    check("basic_load", {32'h0, bus.out}, 64'h0);

    // Load and hold.
    bus.in   = 32'hFFFF_AAAA;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    check("load_edge", {32'h0, bus.out}, 64'hFFFF_AAAA);
    for (int i = 0; i < 3; i++) step();
    check("load_hold", {32'h0, bus.out}, 64'hFFFF_AAAA);

    // Input changes ignored while load is low.
    bus.in = 32'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("ignore_in", {32'h0, bus.out}, 64'hFFFF_AAAA);
    end

    // Load pulse that falls before the next rising edge has no effect.
    bus.in   = 32'h1234_5678;
    bus.load = 1'b1;
    #2;
    bus.load = 1'b0;
    step();
    check("short_pulse", {32'h0, bus.out}, 64'hFFFF_AAAA);

    // Asynchronous clear between edges.
    @(negedge clk);
    rst_n = 1'b0;
    exp32 = '0;
    exp1  = 1'b0;
    #1;
    check("async_clear", {32'h0, bus.out}, 64'h0);
    rst_n = 1'b1;
    step();
    check("after_clear", {32'h0, bus.out}, 64'h0);

    // Single-bit cell: in = 1 without load for two edges, then one load edge.
    bus1.in   = 1'b1;
    bus1.load = 1'b0;
    step();
    step();
    check("w1_no_load", {63'h0, bus1.out}, 64'h0);
    bus1.load = 1'b1;
    step();
    bus1.load = 1'b0;
    check("w1_load", {63'h0, bus1.out}, 64'h1);

    // Back-to-back loads: each edge captures its own word.
    bus.load = 1'b1;
    bus.in   = 32'hA5A5_0001;
    step();
    check("b2b_0", {32'h0, bus.out}, 64'hA5A5_0001);
    bus.in = 32'h5A5A_0002;
    step();
    check("b2b_1", {32'h0, bus.out}, 64'h5A5A_0002);
    bus.load = 1'b0;

    // Random traffic with occasional mid-cycle clears.
    for (int i = 0; i < 300; i++) begin
      bus.in    = $urandom;
      bus.load  = ($urandom_range(0, 2) == 0);
      bus1.in   = $urandom_range(0, 1);
      bus1.load = $urandom_range(0, 1);
      if ($urandom_range(0, 24) == 0) begin
        #2;
        rst_n = 1'b0;
        exp32 = '0;
        exp1  = 1'b0;
        #1;
        check_both("rand_clear");
        rst_n = 1'b1;
      end
      step();
      check_both("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
